// File: rtl/z16_fetch_unit.sv
// z16_fetch_unit: Z16 fetch stage (PC, pipelined 16-bit imem reads, instruction buffer, decoder handshake).
// Latency: grant in N -> o_instr_valid in N+2 (N+1 when Z16_FETCH_BYPASS_EN is defined).
// Backpressure: fetch stops once buffered + in-flight words reach FIFO_DEPTH; i_imem_gnt low holds the request.

// Small synchronous FIFO with flush; pointers wrap naturally because DEPTH is a power of two.
// Latency: push visible at head the cycle after it is written.
// Backpressure: caller guarantees no push when full; pop on empty is ignored.
module z16_fetch_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush,
  input  logic                      push_vld,
  input  logic [W-1:0]              push_dat,
  input  logic                      pop,
  output logic [W-1:0]              head_dat,
  output logic [$clog2(DEPTH):0]    count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign do_pop   = pop && (count != '0);
  assign do_push  = push_vld && ((count != FULL_CNT) || do_pop);
  assign head_dat = mem[rd_ptr];

  // Storage write; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

  // Pointers and occupancy; flush empties the buffer in one cycle.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end
endmodule

module z16_fetch_unit #(
  parameter logic [15:0] RESET_PC   = 16'h0000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  output logic [15:0] o_imem_addr,
  output logic        o_imem_req,
  input  logic        i_imem_gnt,
  input  logic [15:0] i_imem_rdata,
  input  logic        i_redirect,
  input  logic [15:0] i_redirect_pc,
  output logic [15:0] o_instr,
  output logic [15:0] o_instr_pc,
  output logic        o_instr_valid,
  input  logic        i_instr_ready
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_CNT = FIFO_DEPTH[AW:0];

  typedef enum logic {BOOT, RUN} state_t;

  typedef struct packed {
    logic [15:0] instr;
    logic [15:0] pc;
  } fetch_ent_t;

  state_t      state;
  state_t      state_nxt;
  logic [15:0] pc;
  logic [15:0] tag_pc;
  logic        inflight;
  logic        drop;
  logic        req_acc;
  logic        resp_ok;
  logic        push_vld;
  logic        pop;
  logic [AW:0] count;
  fetch_ent_t  push_ent;
  fetch_ent_t  head_ent;
  logic        redirect_pc_lsb_unused;
`ifdef Z16_FETCH_BYPASS_EN
  logic        byp;
`endif

  // Instruction addresses are halfword aligned; the redirect LSB carries no information.
  assign redirect_pc_lsb_unused = i_redirect_pc[0];

  assign o_imem_addr = pc;
  assign req_acc     = o_imem_req && i_imem_gnt;
  assign resp_ok     = inflight && !drop && !i_redirect;
  assign push_ent    = '{instr: i_imem_rdata, pc: tag_pc};
  // Only FIFO-held words are popped; a bypassed word is consumed by simply not pushing it.
  assign pop         = o_instr_valid && i_instr_ready && (count != '0);

  z16_fetch_fifo #(
    .W     ($bits(fetch_ent_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (i_clk),
    .rst_n    (i_rst_n),
    .flush    (i_redirect),
    .push_vld (push_vld),
    .push_dat (push_ent),
    .pop      (pop),
    .head_dat (head_ent),
    .count    (count)
  );

  // State register.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) state <= BOOT;
    else          state <= state_nxt;
  end

  // Next state, request gating and decoder-side outputs.
  always_comb begin
    state_nxt     = state;
    o_imem_req    = 1'b0;
    o_instr_valid = 1'b0;
    o_instr       = '0;
    o_instr_pc    = '0;
    push_vld      = 1'b0;
`ifdef Z16_FETCH_BYPASS_EN
    byp           = 1'b0;
`endif
    case (state)
      BOOT:    state_nxt = RUN;
      // Credit excludes a same-cycle pop, so the buffer cannot overflow.
      RUN:     o_imem_req = !i_redirect && ((count + {{AW{1'b0}}, inflight}) < DEPTH_CNT);
      default: state_nxt = BOOT;
    endcase
    if (count != '0) begin
      o_instr       = head_ent.instr;
      o_instr_pc    = head_ent.pc;
      o_instr_valid = !i_redirect;
    end
`ifdef Z16_FETCH_BYPASS_EN
    else if (resp_ok) begin
      byp           = 1'b1;
      o_instr       = i_imem_rdata;
      o_instr_pc    = tag_pc;
      o_instr_valid = 1'b1;
    end
    push_vld = resp_ok && !(byp && i_instr_ready);
`else
    push_vld = resp_ok;
`endif
  end

  // Program counter and the single outstanding-request tracker.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      pc       <= RESET_PC;
      tag_pc   <= '0;
      inflight <= 1'b0;
      drop     <= 1'b0;
    end else begin
      inflight <= req_acc;
      // The request is already masked during a redirect, so drop only
      // fires if that gating is ever relaxed.
      drop     <= i_redirect && req_acc;
      if (req_acc) tag_pc <= pc;
      if (i_redirect)   pc <= {i_redirect_pc[15:1], 1'b0};
      else if (req_acc) pc <= pc + 16'd2;
    end
  end
endmodule

// File: tb/tb_z16_fetch_unit.sv
// Bench for z16_fetch_unit: randomized fetch traffic checked against a program-order model
// (next expected PC, memory word = address ^ key). A second instance covers RESET_PC = 16'hFFFC.
`timescale 1ns/1ps
module tb_z16_fetch_unit;
`ifdef Z16_FETCH_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif
  localparam int FIRST = 2 + LAT;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, imem_gnt, redirect, instr_ready;
  logic [15:0] redirect_pc, imem_rdata, imem_rdata2;
  logic [15:0] imem_addr, imem_addr2, instr, instr2, instr_pc, instr_pc2;
  logic        imem_req, imem_req2, instr_valid, instr_valid2;

  z16_fetch_unit dut (
    .i_clk(clk), .i_rst_n(rst_n), .o_imem_addr(imem_addr), .o_imem_req(imem_req),
    .i_imem_gnt(imem_gnt), .i_imem_rdata(imem_rdata), .i_redirect(redirect),
    .i_redirect_pc(redirect_pc), .o_instr(instr), .o_instr_pc(instr_pc),
    .o_instr_valid(instr_valid), .i_instr_ready(instr_ready));

  z16_fetch_unit #(.RESET_PC(16'hFFFC)) dut2 (
    .i_clk(clk), .i_rst_n(rst_n), .o_imem_addr(imem_addr2), .o_imem_req(imem_req2),
    .i_imem_gnt(imem_gnt), .i_imem_rdata(imem_rdata2), .i_redirect(redirect),
    .i_redirect_pc(redirect_pc), .o_instr(instr2), .o_instr_pc(instr_pc2),
    .o_instr_valid(instr_valid2), .i_instr_ready(instr_ready));

  int          vectors, miscompares;
  logic [15:0] key;
  logic        pend_vld, pend2_vld;
  logic [15:0] pend_addr, pend2_addr;
  logic        s_req, s_valid, s2_valid;
  logic [15:0] s_addr, s_pc, s_instr, s2_pc, s2_instr;
  logic        l_stall;
  logic [15:0] l_addr;
  logic [15:0] exp_pc, exp_issue, exp2;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return a ^ key;
  endfunction

  // One clock: drive inputs and memory responses after the edge, sample at the falling edge.
  task automatic tick(input logic rn, input logic g, input logic r, input logic rd, input logic [15:0] rpc);
    l_stall = s_req && !imem_gnt;
    l_addr  = s_addr;
    @(posedge clk); #1;
    rst_n = rn; imem_gnt = g; instr_ready = r; redirect = rd; redirect_pc = rpc;
    imem_rdata  = pend_vld  ? mem_word(pend_addr)  : 16'($urandom);
    imem_rdata2 = pend2_vld ? mem_word(pend2_addr) : 16'($urandom);
    @(negedge clk);
    s_req = imem_req; s_addr = imem_addr; s_valid = instr_valid; s_pc = instr_pc; s_instr = instr;
    s2_valid = instr_valid2; s2_pc = instr_pc2; s2_instr = instr2;
    pend_vld  = imem_req && imem_gnt;  pend_addr  = imem_addr;
    pend2_vld = imem_req2 && imem_gnt; pend2_addr = imem_addr2;
  endtask

  task automatic do_reset();
    tick(1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
    tick(1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
    exp_pc = 16'h0000; exp_issue = 16'h0000; exp2 = 16'hFFFC;
  endtask

  task automatic test_reset();
    key = 16'h0000;
    do_reset();
    vectors++;
    if ({s_req, s_valid, s_addr, s_instr, s_pc} !== 35'h0) begin
      miscompares++;
      $display("FAIL reset_outputs got req=%0d valid=%0d addr=%h instr=%h pc=%h want all 0",
               s_req, s_valid, s_addr, s_instr, s_pc);
    end
    vectors++;
    if (imem_addr2 !== 16'hFFFC) begin
      miscompares++;
      $display("FAIL reset_addr_fffc got %h want fffc", imem_addr2);
    end
  endtask

  task automatic test_startup();
    key = 16'h0000;
    do_reset();
    for (int c = 1; c <= 14; c++) begin
      tick(1'b1, 1'b1, 1'b1, 1'b0, 16'h0);
      vectors++;
      if (c < 2) begin
        if (s_req !== 1'b0) begin miscompares++; $display("FAIL startup_boot_req c=%0d got %0d want 0", c, s_req); end
      end else begin
        if (s_req !== 1'b1 || s_addr !== exp_issue) begin
          miscompares++; $display("FAIL startup_req c=%0d got req=%0d addr=%h want 1 %h", c, s_req, s_addr, exp_issue);
        end
        exp_issue += 16'd2;
      end
      vectors++;
      if (c < FIRST) begin
        if (s_valid !== 1'b0) begin miscompares++; $display("FAIL startup_early_valid c=%0d got 1 want 0", c); end
      end else begin
        if (s_valid !== 1'b1 || s_pc !== exp_pc || s_instr !== mem_word(exp_pc)) begin
          miscompares++;
          $display("FAIL startup_pop c=%0d got v=%0d pc=%h instr=%h want 1 %h %h", c, s_valid, s_pc, s_instr, exp_pc, mem_word(exp_pc));
        end
        exp_pc += 16'd2;
      end
    end
  endtask

  task automatic test_reset_pc();
    int n2;
    key = 16'h7E11;
    do_reset();
    n2 = 0;
    for (int c = 1; c <= 10; c++) begin
      tick(1'b1, 1'b1, 1'b1, 1'b0, 16'h0);
      if (s2_valid) begin
        vectors++;
        if (s2_pc !== exp2 || s2_instr !== mem_word(exp2)) begin
          miscompares++; $display("FAIL wrap_pop c=%0d got pc=%h instr=%h want %h %h", c, s2_pc, s2_instr, exp2, mem_word(exp2));
        end
        exp2 += 16'd2; n2++;
      end
    end
    vectors++;
    if (n2 != 10 - FIRST + 1) begin miscompares++; $display("FAIL wrap_count got %0d want %0d", n2, 10 - FIRST + 1); end
  endtask

  task automatic test_stall();
    int acc;
    key = 16'h3C5A;
    do_reset();
    acc = 0;
    for (int c = 1; c <= 12; c++) begin
      tick(1'b1, 1'b1, 1'b0, 1'b0, 16'h0);
      if (s_req) acc++;
    end
    vectors++;
    if (acc != 4 || s_req !== 1'b0 || s_valid !== 1'b1 || s_pc !== 16'h0000) begin
      miscompares++; $display("FAIL stall_full got acc=%0d req=%0d valid=%0d pc=%h want 4 0 1 0000", acc, s_req, s_valid, s_pc);
    end
    for (int c = 0; c < 5; c++) begin
      tick(1'b1, 1'b1, 1'b1, 1'b0, 16'h0);
      vectors++;
      if (s_valid !== 1'b1 || s_pc !== exp_pc || s_instr !== mem_word(exp_pc)) begin
        miscompares++; $display("FAIL stall_drain c=%0d got v=%0d pc=%h instr=%h want 1 %h %h", c, s_valid, s_pc, s_instr, exp_pc, mem_word(exp_pc));
      end
      exp_pc += 16'd2;
    end
  endtask

  task automatic test_redirect();
    int first, n;
    key = 16'h9009;
    do_reset();
    for (int c = 1; c <= 5; c++) tick(1'b1, 1'b1, 1'b0, 1'b0, 16'h0);
    tick(1'b1, 1'b1, 1'b1, 1'b1, 16'h0101);
    vectors++;
    if (s_valid !== 1'b0 || s_req !== 1'b0) begin
      miscompares++; $display("FAIL redirect_cycle got valid=%0d req=%0d want 0 0", s_valid, s_req);
    end
    exp_pc = 16'h0100;
    first = 0; n = 0;
    for (int t = 7; t <= 14; t++) begin
      tick(1'b1, 1'b1, 1'b1, 1'b0, 16'h0);
      if (s_valid) begin
        if (first == 0) first = t;
        vectors++;
        if (s_pc !== exp_pc || s_instr !== mem_word(exp_pc)) begin
          miscompares++; $display("FAIL redirect_pop t=%0d got pc=%h instr=%h want %h %h", t, s_pc, s_instr, exp_pc, mem_word(exp_pc));
        end
        exp_pc += 16'd2; n++;
      end
    end
    vectors++;
    if (first != 6 + LAT + 1 || n != 14 - (6 + LAT + 1) + 1) begin
      miscompares++; $display("FAIL redirect_latency got first=%0d n=%0d want %0d %0d", first, n, 7 + LAT, 8 - LAT);
    end
  endtask

  task automatic test_random();
    int pops;
    logic g, r, rd;
    logic [15:0] rpc;
    key = 16'hC3A5;
    do_reset();
    pops = 0;
    for (int t = 0; t < 250; t++) begin
      g   = (t >= 220) ? 1'b1 : 1'($urandom_range(0, 1));
      r   = (t >= 220) ? 1'b1 : 1'($urandom_range(0, 1));
      rd  = (t >= 2) && (t < 220) && ($urandom_range(0, 15) == 0);
      rpc = 16'($urandom);
      tick(1'b1, g, r, rd, rpc);
      if (rd) begin
        vectors++;
        if (s_valid !== 1'b0 || s_req !== 1'b0) begin
          miscompares++; $display("FAIL rand_redirect t=%0d got valid=%0d req=%0d want 0 0", t, s_valid, s_req);
        end
        exp_pc = {rpc[15:1], 1'b0}; exp_issue = exp_pc;
      end else begin
        if (l_stall) begin
          vectors++;
          if (s_req !== 1'b1 || s_addr !== l_addr) begin
            miscompares++; $display("FAIL rand_hold t=%0d got req=%0d addr=%h want 1 %h", t, s_req, s_addr, l_addr);
          end
        end
        if (s_valid && r) begin
          vectors++;
          if (s_pc !== exp_pc || s_instr !== mem_word(exp_pc)) begin
            miscompares++; $display("FAIL rand_pop t=%0d got pc=%h instr=%h want %h %h", t, s_pc, s_instr, exp_pc, mem_word(exp_pc));
          end
          exp_pc += 16'd2; pops++;
        end
        if (s_req && g) begin
          vectors++;
          if (s_addr !== exp_issue) begin
            miscompares++; $display("FAIL rand_issue t=%0d got %h want %h", t, s_addr, exp_issue);
          end
          exp_issue += 16'd2;
        end
      end
    end
    vectors++;
    if (pops < 40) begin miscompares++; $display("FAIL rand_progress got %0d pops want >=40", pops); end
  endtask

  task automatic test_reset_mid();
    int first;
    key = 16'h5AA5;
    do_reset();
    for (int c = 1; c <= 4; c++) tick(1'b1, 1'b1, 1'b0, 1'b0, 16'h0);
    tick(1'b0, 1'b1, 1'b0, 1'b0, 16'h0);
    tick(1'b1, 1'b1, 1'b1, 1'b0, 16'h0);
    vectors++;
    if ({s_req, s_valid, s_addr, s_instr, s_pc} !== 35'h0) begin
      miscompares++;
      $display("FAIL midreset_outputs got req=%0d valid=%0d addr=%h instr=%h pc=%h want all 0", s_req, s_valid, s_addr, s_instr, s_pc);
    end
    exp_pc = 16'h0000;
    first = 0;
    for (int t = 7; t <= 14; t++) begin
      tick(1'b1, 1'b1, 1'b1, 1'b0, 16'h0);
      if (s_valid) begin
        if (first == 0) first = t;
        vectors++;
        if (s_pc !== exp_pc || s_instr !== mem_word(exp_pc)) begin
          miscompares++; $display("FAIL midreset_pop t=%0d got pc=%h instr=%h want %h %h", t, s_pc, s_instr, exp_pc, mem_word(exp_pc));
        end
        exp_pc += 16'd2;
      end
    end
    vectors++;
    if (first != 5 + FIRST) begin miscompares++; $display("FAIL midreset_latency got %0d want %0d", first, 5 + FIRST); end
  endtask

  initial begin
    vectors = 0; miscompares = 0; key = 16'h0;
    pend_vld = 1'b0; pend2_vld = 1'b0; pend_addr = '0; pend2_addr = '0;
    s_req = 1'b0; s_addr = '0; s_valid = 1'b0; s_pc = '0; s_instr = '0;
    s2_valid = 1'b0; s2_pc = '0; s2_instr = '0; l_stall = 1'b0; l_addr = '0;
    exp_pc = '0; exp_issue = '0; exp2 = '0;
    rst_n = 1'b0; imem_gnt = 1'b0; instr_ready = 1'b0; redirect = 1'b0;
    redirect_pc = '0; imem_rdata = '0; imem_rdata2 = '0;
    test_reset();
    test_startup();
    test_reset_pc();
    test_stall();
    test_redirect();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
